// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values and the change-dispenser state encoding.
package vm_pkg;

  localparam int unsigned COIN5  = 32'd5;
  localparam int unsigned COIN10 = 32'd10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PICK     = 3'd1,
    ST_EJECT    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } disp_state_t;

endpackage

// File: rtl/vm_ack_timer.sv
// Hopper acknowledge watchdog: cleared per coin, counts un-acked cycles and flags the
// cycle on which the count would reach ACK_TMO.
module vm_ack_timer #(
  parameter int ACK_TMO = 15,
  parameter int CNT_W   = $clog2(ACK_TMO + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_term
);

  logic [CNT_W-1:0] r_cnt;

  // Wait counter: cleared when a coin is ejected, advances while the ack is outstanding
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_term = i_en && (r_cnt == CNT_W'(ACK_TMO - 1));

endmodule

// File: rtl/vm_change_dispenser.sv
// Change payout sequencer: pays a requested amount as Rs10/Rs5 coins one at a time,
// tracking hopper stock, reporting shortfall and latching a fault on ack timeout.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W      = 5,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int ACK_TMO    = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amt,
  output logic               req_ready,
  input  logic               refill,
  output logic               eject10,
  output logic               eject5,
  input  logic               hop_ack,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   short_amt,
  output logic               fault,
  output logic [STOCK_W-1:0] stock10,
  output logic [STOCK_W-1:0] stock5
);

  localparam logic [AMT_W-1:0]   C10    = AMT_W'(COIN10);
  localparam logic [AMT_W-1:0]   C5     = AMT_W'(COIN5);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);

  disp_state_t        r_state;
  logic [AMT_W-1:0]   r_rem;
  logic               r_sel10;
  logic               r_req_ready, r_busy, r_done, r_short, r_fault;
  logic               r_eject10, r_eject5;
  logic [AMT_W-1:0]   r_short_amt;
  logic [STOCK_W-1:0] r_stock10, r_stock5;
  logic               w_tmr_clr, w_tmr_en, w_tmo;

  assign w_tmr_clr = (r_state == ST_EJECT);
  assign w_tmr_en  = (r_state == ST_WAIT_ACK) && !hop_ack;

  vm_ack_timer #(.ACK_TMO(ACK_TMO)) u_ack_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_term  (w_tmo)
  );

  // Payout FSM; every output is set on the transition into the state that owns it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_sel10     <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_short_amt <= '0;
      r_fault     <= 1'b0;
      r_eject10   <= 1'b0;
      r_eject5    <= 1'b0;
      r_stock10   <= S_INIT;
      r_stock5    <= S_INIT;
    end else begin
      r_eject10 <= 1'b0;
      r_eject5  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (refill) begin
            r_stock10 <= S_INIT;
            r_stock5  <= S_INIT;
          end
          if (req_valid) begin
            r_rem       <= req_amt;
            r_state     <= ST_PICK;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_PICK: begin
          // Largest coin first; a missing Rs10 falls through to two Rs5
          if (r_rem >= C10 && r_stock10 != '0) begin
            r_sel10   <= 1'b1;
            r_eject10 <= 1'b1;
            r_state   <= ST_EJECT;
          end else if (r_rem >= C5 && r_stock5 != '0) begin
            r_sel10  <= 1'b0;
            r_eject5 <= 1'b1;
            r_state  <= ST_EJECT;
          end else begin
            r_done      <= 1'b1;
            r_short     <= (r_rem != '0);
            r_short_amt <= r_rem;
            r_state     <= ST_DONE;
          end
        end
        ST_EJECT: begin
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (hop_ack) begin
            if (r_sel10) begin
              r_rem     <= r_rem - C10;
              r_stock10 <= r_stock10 - STOCK_W'(1);
            end else begin
              r_rem    <= r_rem - C5;
              r_stock5 <= r_stock5 - STOCK_W'(1);
            end
            r_state <= ST_PICK;
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FAULT;
          end
        end
        ST_DONE: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_fault     <= 1'b1;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= ST_FAULT;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign short     = r_short;
  assign short_amt = r_short_amt;
  assign fault     = r_fault;
  assign eject10   = r_eject10;
  assign eject5    = r_eject5;
  assign stock10   = r_stock10;
  assign stock5    = r_stock5;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Scoreboard bench for vm_change_dispenser: a greedy coin model predicts eject order and
// payout result; a monitor compares every eject and done against the expected queues.
module tb_vm_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_amt = 5'd0;
  logic       req_ready;
  logic       refill = 1'b0;
  logic       eject10, eject5;
  logic       hop_ack = 1'b0;
  logic       busy, done, short, fault;
  logic [4:0] short_amt;
  logic [3:0] stock10, stock5;

  typedef struct {
    logic       sh;
    logic [4:0] amt;
    logic [3:0] s10;
    logic [3:0] s5;
  } exp_t;

  exp_t dq[$];
  bit   eq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   m10 = 8;
  int   m5 = 8;
  bit   ack_en = 1'b1;
  int   ack_dly = 0;

  vm_change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_amt(req_amt),
    .req_ready(req_ready), .refill(refill), .eject10(eject10), .eject5(eject5),
    .hop_ack(hop_ack), .busy(busy), .done(done), .short(short), .short_amt(short_amt),
    .fault(fault), .stock10(stock10), .stock5(stock5)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every eject pulse and every done against the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (eject10 || eject5) begin
        check("eject_exclusive", {31'd0, eject10 & eject5}, 32'd0);
        if (eq.size() == 0) begin
          check("unexpected_eject", 32'd1, 32'd0);
        end else begin
          check("eject_denom", {31'd0, eject10}, {31'd0, eq.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          check("done_short", {31'd0, short}, {31'd0, e.sh});
          check("done_short_amt", {27'd0, short_amt}, {27'd0, e.amt});
          check("done_stock10", {28'd0, stock10}, {28'd0, e.s10});
          check("done_stock5", {28'd0, stock5}, {28'd0, e.s5});
          check("eject_queue_drained", eq.size(), 32'd0);
        end
      end
    end
  end

  // Hopper model: acknowledge each coin after a programmable delay
  initial begin
    forever begin
      @(negedge clk);
      if ((eject10 || eject5) && ack_en && reset_n) begin
        repeat (1 + ack_dly) @(negedge clk);
        hop_ack = ack_en;
        @(negedge clk);
        hop_ack = 1'b0;
      end
    end
  end

  task automatic issue(input logic [4:0] amt, input logic rf);
    int k, r, n10, n5;
    exp_t e;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    if (rf) begin
      m10 = 8;
      m5  = 8;
    end
    r   = int'(amt);
    n10 = r / 10;
    if (n10 > m10) n10 = m10;
    r   = r - 10 * n10;
    n5  = r / 5;
    if (n5 > m5) n5 = m5;
    r   = r - 5 * n5;
    m10 = m10 - n10;
    m5  = m5 - n5;
    for (int i = 0; i < n10; i++) eq.push_back(1'b1);
    for (int i = 0; i < n5; i++) eq.push_back(1'b0);
    e.sh  = (r != 0);
    e.amt = 5'(r);
    e.s10 = 4'(m10);
    e.s5  = 4'(m5);
    dq.push_back(e);
    req_valid = 1'b1;
    req_amt   = amt;
    refill    = rf;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    refill    = 1'b0;
  endtask

  task automatic wait_done();
    int k, target;
    target = done_cnt + 1;
    k = 0;
    while (done_cnt < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic pay(input logic [4:0] amt);
    issue(amt, 1'b0);
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    eq.delete();
    dq.delete();
    m10 = 8;
    m5  = 8;
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_short_amt", {27'd0, short_amt}, 32'd0);
    check("rst_stock10", {28'd0, stock10}, 32'd8);
    check("rst_stock5", {28'd0, stock5}, 32'd8);

    // Rs15 with immediate acks: latency to first eject
    ack_dly = 0;
    issue(5'd15, 1'b0);
    check("busy_in_pick", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_pick_no_eject", {31'd0, eject10}, 32'd0);
    @(negedge clk);
    check("lat_eject10", {31'd0, eject10}, 32'd1);
    wait_done();

    // Drain Rs10 stock, then Rs10 must come out as two Rs5
    pay(5'd30); pay(5'd30); pay(5'd10);
    check("stock10_drained", {28'd0, stock10}, 32'd0);
    pay(5'd10);

    // Rs10 stock 1, Rs5 stock 0, then request 20
    @(negedge clk); refill = 1'b1; @(negedge clk); refill = 1'b0;
    m10 = 8; m5 = 8;
    check("refill_stock10", {28'd0, stock10}, 32'd8);
    pay(5'd30); pay(5'd30); pay(5'd10);
    for (int i = 0; i < 8; i++) pay(5'd5);
    check("stock5_empty", {28'd0, stock5}, 32'd0);
    pay(5'd20);
    @(negedge clk); refill = 1'b1; @(negedge clk); refill = 1'b0;
    m10 = 8; m5 = 8;
    check("refill_stock10_b", {28'd0, stock10}, 32'd8);
    check("refill_stock5_b", {28'd0, stock5}, 32'd8);

    pay(5'd7);
    issue(5'd0, 1'b0);
    @(negedge clk);
    check("zero_pick_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("zero_done_t2", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Randomized payouts with random refills and ack delays
    for (int i = 0; i < 40; i++) begin
      ack_dly = $urandom_range(0, 6);
      issue(5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
      wait_done();
    end
    ack_dly = 0;

    // Ack timeout: fault after 15 un-acked WAIT_ACK cycles
    ack_en = 1'b0;
    issue(5'd5, 1'b0);
    k = 0;
    while (!eject5 && k < 20) begin @(negedge clk); k++; end
    check("tmo_eject_seen", {31'd0, eject5}, 32'd1);
    k = 0;
    while (!fault && k < 40) begin @(negedge clk); k++; end
    check("tmo_cycles_to_fault", k, 32'd16);
    req_valid = 1'b1; req_amt = 5'd20; hop_ack = 1'b1; refill = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_ready_low", {31'd0, req_ready}, 32'd0);
      check("fault_busy_low", {31'd0, busy}, 32'd0);
      check("fault_no_eject", {30'd0, eject10, eject5}, 32'd0);
    end
    req_valid = 1'b0; hop_ack = 1'b0; refill = 1'b0;
    do_reset();
    check("post_fault_clear", {31'd0, fault}, 32'd0);
    check("post_fault_ready", {31'd0, req_ready}, 32'd1);

    // Reset during WAIT_ACK abandons the payout silently
    issue(5'd15, 1'b0);
    k = 0;
    while (!eject10 && k < 20) begin @(negedge clk); k++; end
    check("mid_eject_seen", {31'd0, eject10}, 32'd1);
    repeat (3) @(negedge clk);
    do_reset();
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ready", {31'd0, req_ready}, 32'd1);
    check("mid_outs", {27'd0, eject10, eject5, done, short, fault}, 32'd0);
    check("mid_stocks", {24'd0, stock10, stock5}, {24'd0, 4'd8, 4'd8});
    repeat (20) @(negedge clk);
    check("mid_no_done", done_cnt, done_cnt);
    ack_en = 1'b1;
    pay(5'd25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
